// File: rtl/exe_stage.sv
// Execute stage: one-entry pipeline register, ALU, data-SRAM request issue, valid/allowin handshake to MS.
// Optional macro ES_FWD_BUS_EN adds es_to_ds_bus (bypass value plus load-use hint for decode).
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // alu_op one-hot: add sub slt sltu and nor or xor sll srl sra lui (bit 0..11)
    logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
    logic        adder_inv;
    logic [31:0] adder_b;
    logic [32:0] adder_full;
    logic [31:0] adder_sum;
    logic        slt_res, sltu_res;
    logic [4:0]  shamt;
    logic [31:0] sll_res, srl_res, sra_res;

    assign {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
            op_nor, op_and, op_sltu, op_slt, op_sub, op_add} = alu_op;

    // Subtraction and both compares share the adder as a + ~b + 1.
    assign adder_inv  = op_sub | op_slt | op_sltu;
    assign adder_b    = adder_inv ? ~alu_src2 : alu_src2;
    assign adder_full = {1'b0, alu_src1} + {1'b0, adder_b} + {32'b0, adder_inv};
    assign adder_sum  = adder_full[31:0];

    assign slt_res  = (alu_src1[31] & ~alu_src2[31])
                    | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_res = ~adder_full[32];

    assign shamt   = alu_src2[4:0];
    assign sll_res = alu_src1 << shamt;
    assign srl_res = alu_src1 >> shamt;
    assign sra_res = $unsigned($signed(alu_src1) >>> shamt);

    assign alu_result = ({32{op_add | op_sub}} & adder_sum)
                      | ({32{op_slt}}          & {31'b0, slt_res})
                      | ({32{op_sltu}}         & {31'b0, sltu_res})
                      | ({32{op_and}}          & (alu_src1 & alu_src2))
                      | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
                      | ({32{op_or}}           & (alu_src1 | alu_src2))
                      | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
                      | ({32{op_sll}}          & sll_res)
                      | ({32{op_srl}}          & srl_res)
                      | ({32{op_sra}}          & sra_res)
                      | ({32{op_lui}}          & alu_src2);
endmodule

module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 150,
    parameter int ES_TO_MS_BUS_WD = 71
`ifdef ES_FWD_BUS_EN
    ,
    parameter int ES_TO_DS_BUS_WD = 39
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
`ifdef ES_FWD_BUS_EN
    output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
`endif
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    logic                       es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus;
    logic                       es_ready_go;

    logic [11:0] es_alu_op;
    logic        es_load_op, es_src1_is_pc, es_src2_is_imm, es_gr_we, es_mem_we;
    logic [4:0]  es_dest;
    logic [31:0] es_imm, es_rj_value, es_rkd_value, es_pc;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        es_mem_fire;

    assign {es_alu_op, es_load_op, es_src1_is_pc, es_src2_is_imm, es_gr_we, es_mem_we,
            es_dest, es_imm, es_rj_value, es_rkd_value, es_pc} = es_bus;

    assign es_ready_go    = 1'b1;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
        // Bubbles leave es_bus untouched; only a real capture writes it.
        if (!reset && ds_to_es_valid && es_allowin) begin
            es_bus <= ds_to_es_bus;
        end
    end

    assign alu_src1 = es_src1_is_pc  ? es_pc  : es_rj_value;
    assign alu_src2 = es_src2_is_imm ? es_imm : es_rkd_value;

    alu u_alu (
        .alu_op     (es_alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result)
    );

    // Strobe only in the transfer cycle so a stalled access is issued exactly once.
    assign es_mem_fire     = es_valid && ms_allowin && (es_load_op || es_mem_we);
    assign data_sram_en    = es_mem_fire;
    assign data_sram_we    = {4{es_mem_fire && es_mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_rkd_value;

    assign es_to_ms_bus = {es_load_op, es_gr_we, es_dest, alu_result, es_pc};

`ifdef ES_FWD_BUS_EN
    assign es_to_ds_bus = {es_valid && es_gr_we, es_valid && es_load_op, es_dest, alu_result};
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: ALU vector table, handshake corner sequences,
// and randomized traffic against a queue-based model of the one-entry stage.
module tb_exe_stage;
    typedef struct packed {
        logic [11:0] alu_op;
        logic        load_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        string       name;
        logic [11:0] op;
        logic        load_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        mem_we;
        logic [31:0] imm;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic        exp_en;
        logic [3:0]  exp_we;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
`ifdef ES_FWD_BUS_EN
    logic [38:0]  es_to_ds_bus;
`endif

    int checks = 0;
    int errors = 0;
    ins_t cur;
    ins_t q[$];

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
`ifdef ES_FWD_BUS_EN
        .es_to_ds_bus    (es_to_ds_bus),
`endif
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        sa = int'(b[4:0]);
        if (op[0])       return a + b;
        else if (op[1])  return a - b;
        else if (op[2])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (op[3])  return (a < b) ? 32'd1 : 32'd0;
        else if (op[4])  return a & b;
        else if (op[5])  return ~(a | b);
        else if (op[6])  return a | b;
        else if (op[7])  return a ^ b;
        else if (op[8])  return a << sa;
        else if (op[9])  return a >> sa;
        else if (op[10]) return $unsigned($signed(a) >>> sa);
        else             return b;
    endfunction

    function automatic logic [31:0] res_of(input ins_t i);
        return alu_ref(i.alu_op, i.src1_is_pc ? i.pc : i.rj, i.src2_is_imm ? i.imm : i.rkd);
    endfunction

    function automatic ins_t mk(input logic [11:0] op, input logic ld, input logic st,
                                input logic [4:0] dest, input logic [31:0] imm,
                                input logic [31:0] rj, input logic [31:0] rkd,
                                input logic [31:0] pc);
        ins_t i;
        i.alu_op = op; i.load_op = ld; i.src1_is_pc = 1'b0; i.src2_is_imm = ld | st;
        i.gr_we = ~st; i.mem_we = st; i.dest = dest; i.imm = imm;
        i.rj = rj; i.rkd = rkd; i.pc = pc;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        logic [11:0] one;
        int kind;
        one = 12'd1;
        kind = $urandom_range(0, 2);
        i.alu_op      = (kind == 0) ? (one << $urandom_range(0, 11)) : one;
        i.load_op     = (kind == 1);
        i.mem_we      = (kind == 2);
        i.src1_is_pc  = 1'($urandom_range(0, 1));
        i.src2_is_imm = 1'($urandom_range(0, 1));
        i.gr_we       = 1'($urandom_range(0, 1));
        i.dest        = 5'($urandom);
        i.imm         = $urandom;
        i.rj          = $urandom;
        i.rkd         = $urandom;
        i.pc          = $urandom;
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic dv, input logic ma, input ins_t i);
        reset = rst; ds_to_es_valid = dv; ms_allowin = ma; cur = i; ds_to_es_bus = i;
        #4;
    endtask

    // Full comparison of every output against the queue model; q[0] is the instruction held in ES.
    task automatic check_model(input string tag);
        logic        v;
        logic [31:0] r;
        ins_t        e;
        v = (q.size() != 0);
        chk({tag, "_allowin"}, {31'b0, es_allowin}, {31'b0, !v || ms_allowin});
        chk({tag, "_valid"},   {31'b0, es_to_ms_valid}, {31'b0, v});
        if (v) begin
            e = q[0];
            r = res_of(e);
            chk({tag, "_bus_hi"}, {25'b0, es_to_ms_bus[70:64]}, {25'b0, e.load_op, e.gr_we, e.dest});
            chk({tag, "_res"},    es_to_ms_bus[63:32], r);
            chk({tag, "_pc"},     es_to_ms_bus[31:0], e.pc);
            chk({tag, "_en"},     {31'b0, data_sram_en}, {31'b0, ms_allowin && (e.load_op || e.mem_we)});
            chk({tag, "_we"},     {28'b0, data_sram_we}, {28'b0, {4{ms_allowin && e.mem_we}}});
            chk({tag, "_addr"},   data_sram_addr, r);
            chk({tag, "_wdata"},  data_sram_wdata, e.rkd);
`ifdef ES_FWD_BUS_EN
            chk({tag, "_fwd_hi"}, {25'b0, es_to_ds_bus[38:32]}, {25'b0, e.gr_we, e.load_op, e.dest});
            chk({tag, "_fwd_res"}, es_to_ds_bus[31:0], r);
`endif
        end else begin
            chk({tag, "_en_idle"}, {28'b0, data_sram_we, data_sram_en}, 32'd0);
`ifdef ES_FWD_BUS_EN
            chk({tag, "_fwd_idle"}, {30'b0, es_to_ds_bus[38:37]}, 32'd0);
`endif
        end
    endtask

    task automatic model_edge();
        if (reset) q.delete();
        else begin
            if (q.size() != 0 && ms_allowin) void'(q.pop_front());
            if (q.size() == 0 && ds_to_es_valid) q.push_back(cur);
        end
    endtask

    vec_t vt[14];
    ins_t nop, a_i, b_i, c_i, ld_i;

    initial begin
        vt[0]  = '{"add",  12'h001, 0, 0, 0, 0, 32'h0, 32'h00000005, 32'h00000003, 32'h1c000000, 32'h00000008, 0, 4'h0};
        vt[1]  = '{"sub",  12'h002, 0, 0, 0, 0, 32'h0, 32'h00000005, 32'h00000003, 32'h1c000004, 32'h00000002, 0, 4'h0};
        vt[2]  = '{"slt",  12'h004, 0, 0, 0, 0, 32'h0, 32'hffffffff, 32'h00000001, 32'h1c000008, 32'h00000001, 0, 4'h0};
        vt[3]  = '{"sltu", 12'h008, 0, 0, 0, 0, 32'h0, 32'hffffffff, 32'h00000001, 32'h1c00000c, 32'h00000000, 0, 4'h0};
        vt[4]  = '{"and",  12'h010, 0, 0, 0, 0, 32'h0, 32'hf0f0f0f0, 32'hff00ff00, 32'h1c000010, 32'hf000f000, 0, 4'h0};
        vt[5]  = '{"nor",  12'h020, 0, 0, 0, 0, 32'h0, 32'h00000000, 32'h00000000, 32'h1c000014, 32'hffffffff, 0, 4'h0};
        vt[6]  = '{"or",   12'h040, 0, 0, 0, 0, 32'h0, 32'h12340000, 32'h00005678, 32'h1c000018, 32'h12345678, 0, 4'h0};
        vt[7]  = '{"xor",  12'h080, 0, 0, 0, 0, 32'h0, 32'hffff0000, 32'h0ff00ff0, 32'h1c00001c, 32'hf00f0ff0, 0, 4'h0};
        vt[8]  = '{"sll",  12'h100, 0, 0, 0, 0, 32'h0, 32'h00000001, 32'h00000004, 32'h1c000020, 32'h00000010, 0, 4'h0};
        vt[9]  = '{"srl",  12'h200, 0, 0, 0, 0, 32'h0, 32'h80000000, 32'h00000004, 32'h1c000024, 32'h08000000, 0, 4'h0};
        vt[10] = '{"sra",  12'h400, 0, 0, 0, 0, 32'h0, 32'h80000000, 32'h00000004, 32'h1c000028, 32'hf8000000, 0, 4'h0};
        vt[11] = '{"lui",  12'h800, 0, 0, 1, 0, 32'h12345000, 32'h0, 32'h0, 32'h1c00002c, 32'h12345000, 0, 4'h0};
        vt[12] = '{"st_w", 12'h001, 0, 0, 1, 1, 32'h00000004, 32'h1c000100, 32'hdeadbeef, 32'h1c000030, 32'h1c000104, 1, 4'hf};
        vt[13] = '{"pcadd",12'h001, 0, 1, 1, 0, 32'h00000008, 32'h0, 32'h0, 32'h1c000000, 32'h1c000008, 0, 4'h0};

        nop = '0;
        // Reset held two cycles, then idle.
        drive(1, 0, 1, nop);
        tick();
        drive(1, 0, 1, nop);
        chk("rst_valid", {31'b0, es_to_ms_valid}, 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, nop);
            chk("idle_valid",   {31'b0, es_to_ms_valid}, 32'd0);
            chk("idle_en",      {31'b0, data_sram_en}, 32'd0);
            chk("idle_allowin", {31'b0, es_allowin}, 32'd1);
`ifdef ES_FWD_BUS_EN
            chk("idle_fwd", {30'b0, es_to_ds_bus[38:37]}, 32'd0);
`endif
            tick();
        end

        // ALU / memory vector table.
        for (int k = 0; k < 14; k++) begin
            ins_t i;
            i = mk(vt[k].op, vt[k].load_op, vt[k].mem_we, 5'd1, vt[k].imm, vt[k].rj, vt[k].rkd, vt[k].pc);
            i.src1_is_pc  = vt[k].src1_is_pc;
            i.src2_is_imm = vt[k].src2_is_imm;
            drive(0, 1, 1, i);
            tick();
            drive(0, 0, 1, nop);
            chk({vt[k].name, "_valid"}, {31'b0, es_to_ms_valid}, 32'd1);
            chk({vt[k].name, "_res"},   es_to_ms_bus[63:32], vt[k].exp_res);
            chk({vt[k].name, "_pc"},    es_to_ms_bus[31:0], vt[k].pc);
            chk({vt[k].name, "_en"},    {31'b0, data_sram_en}, {31'b0, vt[k].exp_en});
            chk({vt[k].name, "_we"},    {28'b0, data_sram_we}, {28'b0, vt[k].exp_we});
            if (vt[k].exp_en) begin
                chk({vt[k].name, "_addr"},  data_sram_addr, vt[k].exp_res);
                chk({vt[k].name, "_wdata"}, data_sram_wdata, vt[k].rkd);
            end
            tick();
            drive(0, 0, 1, nop);
            chk({vt[k].name, "_once"}, {31'b0, data_sram_en}, 32'd0);
            tick();
        end

        // ld.w held by MS for three cycles; decode keeps offering another instruction.
        ld_i = mk(12'h001, 1, 0, 5'd5, 32'h8, 32'h1c000200, 32'h0, 32'h1c000400);
        a_i  = mk(12'h001, 0, 0, 5'd7, 32'h0, 32'h1, 32'h2, 32'h1c000404);
        drive(0, 1, 1, ld_i);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, a_i);
            chk("stall_en",      {31'b0, data_sram_en}, 32'd0);
            chk("stall_allowin", {31'b0, es_allowin}, 32'd0);
            chk("stall_valid",   {31'b0, es_to_ms_valid}, 32'd1);
            chk("stall_pc",      es_to_ms_bus[31:0], 32'h1c000400);
            chk("stall_res",     es_to_ms_bus[63:32], 32'h1c000208);
`ifdef ES_FWD_BUS_EN
            chk("fwd_ld", {25'b0, es_to_ds_bus[38:32]}, {25'b0, 2'b11, 5'd5});
`endif
            tick();
        end
        drive(0, 0, 1, nop);
        chk("ld_rel_en",   {31'b0, data_sram_en}, 32'd1);
        chk("ld_rel_we",   {28'b0, data_sram_we}, 32'd0);
        chk("ld_rel_addr", data_sram_addr, 32'h1c000208);
        tick();
        drive(0, 0, 1, nop);
        chk("ld_after_en",    {31'b0, data_sram_en}, 32'd0);
        chk("ld_after_valid", {31'b0, es_to_ms_valid}, 32'd0);
`ifdef ES_FWD_BUS_EN
        chk("fwd_bubble", {30'b0, es_to_ds_bus[38:37]}, 32'd0);
`endif
        tick();

        // Three back-to-back instructions.
        a_i = mk(12'h001, 0, 0, 5'd1, 32'h0, 32'h1, 32'h1, 32'h1c000500);
        b_i = mk(12'h001, 0, 0, 5'd2, 32'h0, 32'h2, 32'h2, 32'h1c000504);
        c_i = mk(12'h001, 0, 0, 5'd3, 32'h0, 32'h3, 32'h3, 32'h1c000508);
        drive(0, 1, 1, a_i);
        tick();
        drive(0, 1, 1, b_i);
        chk("b2b_v0",  {31'b0, es_to_ms_valid}, 32'd1);
        chk("b2b_pc0", es_to_ms_bus[31:0], 32'h1c000500);
        chk("b2b_al0", {31'b0, es_allowin}, 32'd1);
        tick();
        drive(0, 1, 1, c_i);
        chk("b2b_v1",  {31'b0, es_to_ms_valid}, 32'd1);
        chk("b2b_pc1", es_to_ms_bus[31:0], 32'h1c000504);
        chk("b2b_r1",  es_to_ms_bus[63:32], 32'h4);
        tick();
        drive(0, 0, 1, nop);
        chk("b2b_v2",  {31'b0, es_to_ms_valid}, 32'd1);
        chk("b2b_pc2", es_to_ms_bus[31:0], 32'h1c000508);
        tick();
        drive(0, 0, 1, nop);
        chk("b2b_end", {31'b0, es_to_ms_valid}, 32'd0);
        tick();

        // Reset arriving while a store is stalled.
        a_i = mk(12'h001, 0, 1, 5'd0, 32'h4, 32'h1c000100, 32'h12345678, 32'h1c000600);
        drive(0, 1, 1, a_i);
        tick();
        drive(0, 0, 0, nop);
        chk("rs_stall_en", {31'b0, data_sram_en}, 32'd0);
        tick();
        drive(1, 0, 0, nop);
        tick();
        drive(0, 0, 1, nop);
        chk("rs_valid",   {31'b0, es_to_ms_valid}, 32'd0);
        chk("rs_en",      {31'b0, data_sram_en}, 32'd0);
        chk("rs_allowin", {31'b0, es_allowin}, 32'd1);
        tick();

        // Randomized traffic against the queue model.
        q.delete();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), rand_ins());
            check_model("rnd");
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
